// File: rtl/spare_alloc_sequencer.sv
// rtl/spare_alloc_sequencer.sv - exhaustive spare-candidate search sequencer for the spare allocation analyzer
module spare_alloc_sequencer #(
   parameter int PCAM  = 8,
   parameter int NPCAM = 30
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic                abort,
   input  logic [NPCAM-1:0]    np_valid,
   input  logic [NPCAM-1:0]    np_cover,
   input  logic                must_uncover,
   output logic [PCAM-1:0]     dsss,
   output logic [3:0]          rlss,
   output logic                busy,
   output logic                done,
   output logic                repairable,
   output logic [PCAM-1:0]     sol_dsss,
   output logic [3:0]          sol_rlss,
   output logic [PCAM+4:0]     eval_count
);

   typedef enum logic [1:0] {IDLE, APPLY, EVAL, DONE} state_t;

   localparam logic [PCAM+4:0] CNT_MAX = {1'b1, {(PCAM+4){1'b0}}};

   state_t            state, state_nxt;
   logic [PCAM+3:0]   idx, idx_nxt;
   logic [PCAM+4:0]   cnt_nxt;
   logic              rep_nxt;
   logic [PCAM-1:0]   sol_dsss_nxt;
   logic [3:0]        sol_rlss_nxt;
   logic              cand_pass;

   assign cand_pass = ((np_cover & np_valid) == np_valid) && !must_uncover;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         idx        <= '0;
         eval_count <= '0;
         repairable <= 1'b0;
         sol_dsss   <= '0;
         sol_rlss   <= '0;
      end else begin
         state      <= state_nxt;
         idx        <= idx_nxt;
         eval_count <= cnt_nxt;
         repairable <= rep_nxt;
         sol_dsss   <= sol_dsss_nxt;
         sol_rlss   <= sol_rlss_nxt;
      end
   end

   always_comb begin
      state_nxt    = state;
      idx_nxt      = idx;
      cnt_nxt      = eval_count;
      rep_nxt      = repairable;
      sol_dsss_nxt = sol_dsss;
      sol_rlss_nxt = sol_rlss;
      case (state)
         IDLE: begin
            if (start) begin
               idx_nxt      = '0;
               cnt_nxt      = '0;
               rep_nxt      = 1'b0;
               sol_dsss_nxt = '0;
               sol_rlss_nxt = '0;
               state_nxt    = APPLY;
            end
         end
         APPLY: begin
            state_nxt = abort ? DONE : EVAL;
         end
         EVAL: begin
            if (eval_count != CNT_MAX)
               cnt_nxt = eval_count + 1'b1;
            // abort wins over a passing candidate evaluated in the same cycle
            if (abort) begin
               state_nxt = DONE;
            end else if (cand_pass) begin
               rep_nxt      = 1'b1;
               sol_dsss_nxt = idx[PCAM-1:0];
               sol_rlss_nxt = idx[PCAM+3:PCAM];
               state_nxt    = DONE;
            end else if (&idx) begin
               state_nxt = DONE;
            end else begin
               idx_nxt   = idx + 1'b1;
               state_nxt = APPLY;
            end
         end
         DONE: begin
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign busy = (state != IDLE);
   assign done = (state == DONE);
   assign dsss = (state == APPLY || state == EVAL) ? idx[PCAM-1:0]    : '0;
   assign rlss = (state == APPLY || state == EVAL) ? idx[PCAM+3:PCAM] : '0;

endmodule

// File: tb/tb_spare_alloc_sequencer.sv
// tb/tb_spare_alloc_sequencer.sv - table-driven and randomized bench for spare_alloc_sequencer
module tb_spare_alloc_sequencer;

   localparam int PCAM  = 2;
   localparam int NPCAM = 4;

   logic             clk = 1'b0;
   logic             rst, start, abort;
   logic [NPCAM-1:0] np_valid, np_cover;
   logic             must_uncover;
   logic [PCAM-1:0]  dsss, sol_dsss;
   logic [3:0]       rlss, sol_rlss;
   logic             busy, done, repairable;
   logic [PCAM+4:0]  eval_count;

   logic [NPCAM-1:0] cov_tab [64];
   logic             mu_tab  [64];

   int checks = 0;
   int errors = 0;

   spare_alloc_sequencer #(.PCAM(PCAM), .NPCAM(NPCAM)) dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort),
      .np_valid(np_valid), .np_cover(np_cover), .must_uncover(must_uncover),
      .dsss(dsss), .rlss(rlss), .busy(busy), .done(done),
      .repairable(repairable), .sol_dsss(sol_dsss), .sol_rlss(sol_rlss),
      .eval_count(eval_count)
   );

   always #5 clk = ~clk;

   // analyzer model: responds to the candidate currently driven
   assign np_cover     = cov_tab[{rlss, dsss}];
   assign must_uncover = mu_tab[{rlss, dsss}];

   typedef struct {
      logic [3:0] v;
      logic [3:0] dflt;
      int         pidx;
      logic       mu;
      int         ab;
      int         s1;
      int         s2;
      logic       er;
      logic [1:0] esd;
      logic [3:0] esr;
      int         ecnt;
      int         elat;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic fill(input logic [3:0] dflt, input int pidx, input logic mu);
      for (int c = 0; c < 64; c++) begin
         cov_tab[c] = (c == pidx) ? 4'hF : dflt;
         mu_tab[c]  = mu;
      end
   endtask

   // Reference: walk candidates in order, first abort or pass decides
   task automatic model(input int ab, output logic r, output int cnt, output int win);
      r = 1'b0; cnt = 64; win = 0;
      for (int c = 0; c < 64; c++) begin
         if (ab != 0 && c + 1 == ab) begin
            cnt = c + 1;
            return;
         end
         if (((cov_tab[c] & np_valid) == np_valid) && !mu_tab[c]) begin
            r = 1'b1; cnt = c + 1; win = c;
            return;
         end
      end
   endtask

   task automatic run_search(input int ab, input int s1, input int s2, output int lat,
                             output logic r, output logic [1:0] sd, output logic [3:0] sr,
                             output int cnt);
      lat = -1; r = 1'b0; sd = '0; sr = '0; cnt = 0;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int cyc = 1; cyc <= 200; cyc++) begin
         start = (cyc == s1) || (cyc == s2);
         abort = (ab != 0) && (cyc == 2 * ab);
         if (done) begin
            lat = cyc; r = repairable; sd = sol_dsss; sr = sol_rlss; cnt = int'(eval_count);
            chk("done_cand_zero", {26'd0, rlss, dsss}, 32'd0);
            chk("done_busy", {31'd0, busy}, 32'd1);
            break;
         end
         @(posedge clk); #1;
      end
      if (lat < 0) begin
         chk("search_timeout", 32'd0, 32'd1);
         start = 1'b0; abort = 1'b0;
      end else begin
         @(posedge clk); #1;
         start = 1'b0; abort = 1'b0;
         chk("post_done_idle", {29'd0, busy, done, 1'b0}, 32'd0);
         chk("post_done_cand", {26'd0, rlss, dsss}, 32'd0);
         @(posedge clk); #1;
         chk("no_restart", {31'd0, busy}, 32'd0);
      end
   endtask

   vec_t       tv [9];
   int         lat, cnt, mcnt, win;
   logic       r, mr;
   logic [1:0] sd;
   logic [3:0] sr;

   initial begin
      rst = 1'b1; start = 1'b0; abort = 1'b0; np_valid = '0;
      fill(4'h0, -1, 1'b0);
      tv[0] = '{4'h0, 4'h0, -1, 1'b0, 0, 0,  0, 1'b1, 2'd0, 4'h0,  1,   3};
      tv[1] = '{4'hF, 4'h0, 14, 1'b0, 0, 0,  0, 1'b1, 2'd2, 4'h3, 15,  31};
      tv[2] = '{4'hF, 4'h0, -1, 1'b1, 0, 0,  0, 1'b0, 2'd0, 4'h0, 64, 129};
      tv[3] = '{4'hF, 4'h0,  4, 1'b0, 5, 0,  0, 1'b0, 2'd0, 4'h0,  5,  11};
      tv[4] = '{4'hF, 4'h0, 63, 1'b0, 0, 0,  0, 1'b1, 2'd3, 4'hF, 64, 129};
      tv[5] = '{4'hF, 4'h0, 14, 1'b0, 0, 10, 31, 1'b1, 2'd2, 4'h3, 15,  31};
      tv[6] = '{4'hF, 4'h0, -1, 1'b0, 1, 0,  0, 1'b0, 2'd0, 4'h0,  1,   3};
      tv[7] = '{4'h5, 4'h5, -1, 1'b0, 0, 0,  0, 1'b1, 2'd0, 4'h0,  1,   3};
      tv[8] = '{4'h7, 4'h5,  9, 1'b0, 0, 0,  0, 1'b1, 2'd1, 4'h2, 10,  21};

      repeat (3) @(posedge clk);
      #1;
      chk("reset_state", {10'd0, busy, done, repairable, dsss, rlss, sol_dsss, sol_rlss, eval_count}, 32'd0);
      rst = 1'b0;
      @(posedge clk); #1;
      chk("idle_after_reset", {31'd0, busy}, 32'd0);

      for (int i = 0; i < 9; i++) begin
         np_valid = tv[i].v;
         fill(tv[i].dflt, tv[i].pidx, tv[i].mu);
         run_search(tv[i].ab, tv[i].s1, tv[i].s2, lat, r, sd, sr, cnt);
         chk($sformatf("v%0d_latency", i), lat, tv[i].elat);
         chk($sformatf("v%0d_repairable", i), {31'd0, r}, {31'd0, tv[i].er});
         chk($sformatf("v%0d_sol", i), {26'd0, sr, sd}, {26'd0, tv[i].esr, tv[i].esd});
         chk($sformatf("v%0d_eval_count", i), cnt, tv[i].ecnt);
      end

      // reset in IDLE clears the held solution
      rst = 1'b1; #2;
      chk("rst_idle_sol", {26'd0, sol_rlss, sol_dsss}, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;

      // reset mid-search, then a fresh search restarts from idx 0
      np_valid = 4'hF;
      fill(4'h0, -1, 1'b0);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (7) @(posedge clk);
      #1;
      chk("mid_busy", {31'd0, busy}, 32'd1);
      rst = 1'b1; #2;
      chk("mid_rst_outputs", {10'd0, busy, done, repairable, dsss, rlss, sol_dsss, sol_rlss, eval_count}, 32'd0);
      @(posedge clk); #1;
      chk("mid_rst_held", {10'd0, busy, done, repairable, dsss, rlss, sol_dsss, sol_rlss, eval_count}, 32'd0);
      rst = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      chk("rst_no_autostart", {24'd0, busy, eval_count}, 32'd0);
      fill(4'h0, 14, 1'b0);
      run_search(0, 0, 0, lat, r, sd, sr, cnt);
      chk("rst_restart_cnt", cnt, 15);
      chk("rst_restart_sol", {26'd0, sr, sd}, {26'd0, 4'h3, 2'd2});
      chk("rst_restart_lat", lat, 31);

      // randomized searches against the reference model
      for (int t = 0; t < 20; t++) begin
         int ab;
         np_valid = 4'($urandom);
         for (int c = 0; c < 64; c++) begin
            cov_tab[c] = 4'($urandom);
            mu_tab[c]  = ($urandom_range(0, 3) != 0);
         end
         ab = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 64) : 0;
         model(ab, mr, mcnt, win);
         run_search(ab, 0, 0, lat, r, sd, sr, cnt);
         chk($sformatf("rnd%0d_latency", t), lat, 2 * mcnt + 1);
         chk($sformatf("rnd%0d_repairable", t), {31'd0, r}, {31'd0, mr});
         chk($sformatf("rnd%0d_sol", t), {26'd0, sr, sd}, mr ? win : 0);
         chk($sformatf("rnd%0d_eval_count", t), cnt, mcnt);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
